// File: rtl/keccak_msg_feeder.sv
// Byte-stream to 32-bit word feeder for the Keccak core input port, one message per reset.
// Optional msg_bytes counter is enabled by defining KECCAK_FEEDER_BYTECNT_EN.
module keccak_msg_feeder #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    input  logic             s_nobyte,
    output logic             s_ready,
    output logic [31:0]      in,
    output logic             in_ready,
    output logic             is_last,
    output logic [1:0]       byte_num,
    input  logic             buffer_full,
    output logic             done,
    output logic [CNT_W-1:0] msg_bytes
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        SEND = 2'd1,
        TERM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  k_q, k_d;
    logic        last_q, last_d;
    logic [1:0]  bn_q, bn_d;
    logic        term_q, term_d;

    logic beat_acc;
    logic end_nobyte;
    logic data_acc;
    logic xfer;

    assign beat_acc   = s_valid & s_ready;
    assign end_nobyte = s_last & s_nobyte;
    assign data_acc   = beat_acc & ~end_nobyte;
    assign xfer       = in_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= FILL;
            word_q  <= '0;
            k_q     <= '0;
            last_q  <= 1'b0;
            bn_q    <= '0;
            term_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            k_q     <= k_d;
            last_q  <= last_d;
            bn_q    <= bn_d;
            term_q  <= term_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        k_d     = k_q;
        last_d  = last_q;
        bn_d    = bn_q;
        term_d  = term_q;
        case (state_q)
            FILL: begin
                if (beat_acc) begin
                    if (end_nobyte) begin
                        state_d = SEND;
                        last_d  = 1'b1;
                        bn_d    = k_q;
                    end else begin
                        // Lane 0 is the most significant byte
                        word_d = word_q | ({s_data, 24'h000000} >> {k_q, 3'b000});
                        k_d    = k_q + 2'd1;
                        if (k_q == 2'd3) begin
                            state_d = SEND;
                            last_d  = 1'b0;
                            term_d  = s_last;
                        end else if (s_last) begin
                            state_d = SEND;
                            last_d  = 1'b1;
                            bn_d    = k_q + 2'd1;
                        end
                    end
                end
            end
            SEND: begin
                if (xfer) begin
                    if (last_q) begin
                        state_d = DONE;
                    end else if (term_q) begin
                        // Message length was a multiple of 4: owe an empty final word
                        state_d = TERM;
                        word_d  = '0;
                        last_d  = 1'b1;
                        bn_d    = 2'd0;
                        term_d  = 1'b0;
                    end else begin
                        state_d = FILL;
                        word_d  = '0;
                        k_d     = 2'd0;
                    end
                end
            end
            TERM: begin
                if (xfer) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Gated by reset so nothing handshakes while reset is held low
    always_comb begin
        s_ready  = reset & (state_q == FILL);
        in_ready = reset & ((state_q == SEND) | (state_q == TERM)) & ~buffer_full;
        done     = reset & (state_q == DONE);
        in       = word_q;
        is_last  = last_q;
        byte_num = bn_q;
    end

`ifdef KECCAK_FEEDER_BYTECNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (data_acc) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign msg_bytes = cnt_q;
`else
    logic unused_data_acc;
    assign unused_data_acc = data_acc;
    assign msg_bytes       = '0;
`endif

endmodule

// File: tb/tb_keccak_msg_feeder.sv
// Directed scoreboard bench for keccak_msg_feeder.
module tb_keccak_msg_feeder;

    logic        clk;
    logic        reset;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_nobyte;
    logic        s_ready;
    logic [31:0] in;
    logic        in_ready;
    logic        is_last;
    logic [1:0]  byte_num;
    logic        buffer_full;
    logic        done;
    logic [31:0] msg_bytes;

    int total = 0;
    int bad   = 0;
    int cnt   = 0;
    logic [34:0] exp_q[$];

    keccak_msg_feeder #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
        .s_last(s_last), .s_nobyte(s_nobyte), .s_ready(s_ready), .in(in),
        .in_ready(in_ready), .is_last(is_last), .byte_num(byte_num),
        .buffer_full(buffer_full), .done(done), .msg_bytes(msg_bytes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ecnt(input int c);
`ifdef KECCAK_FEEDER_BYTECNT_EN
        return c;
`else
        return 32'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Transfer monitor: a word moves at the next posedge whenever in_ready is high here
    always @(negedge clk) begin
        if (in_ready === 1'b1) begin
            total++;
            assert (buffer_full === 1'b0) else begin
                bad++;
                $error("FAIL in_ready_vs_full observed=1 expected=0");
            end
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("FAIL unexpected_xfer observed=%h/%0b/%0d expected=none", in, is_last, byte_num);
            end
            if (exp_q.size() > 0) begin
                logic [34:0] e;
                e = exp_q.pop_front();
                total++;
                assert ({in, is_last, byte_num} === e) else begin
                    bad++;
                    $error("FAIL xfer observed=%h/%0b/%0d expected=%h/%0b/%0d",
                           in, is_last, byte_num, e[34:3], e[2], e[1:0]);
                end
            end
        end
    end

    task automatic push(input logic [31:0] w, input logic l, input logic [1:0] bn);
        exp_q.push_back({w, l, bn});
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_in", in, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_is_last", {31'd0, is_last}, 32'd0);
        chk("rst_byte_num", {30'd0, byte_num}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_msg_bytes", msg_bytes, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        cnt = 0;
        @(negedge clk);
        chk("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic l, input logic n);
        int  t;
        bit  ok;
        t  = 0;
        ok = 1'b0;
        s_data = d; s_last = l; s_nobyte = n; s_valid = 1'b1;
        while (!ok && t < 50) begin
            @(negedge clk);
            if (s_ready === 1'b1) ok = 1'b1;
            t++;
            @(posedge clk); #1;
        end
        s_valid = 1'b0; s_last = 1'b0; s_nobyte = 1'b0;
        chk("beat_accept_timeout", {31'd0, ok}, 32'd1);
        if (ok && !(l && n)) cnt++;
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (done !== 1'b1 && t < 100);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_sb_empty"}, exp_q.size(), 32'd0);
        chk({tag, "_msg_bytes"}, msg_bytes, ecnt(cnt));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
        s_nobyte = 1'b0; buffer_full = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // 3-byte message
        push(32'h61626300, 1'b1, 2'd3);
        beat(8'h61, 1'b0, 1'b0);
        beat(8'h62, 1'b0, 1'b0);
        beat(8'h63, 1'b1, 1'b0);
        wait_done("abc");

        // 4-byte message needs a terminator word
        do_reset();
        push(32'h01020304, 1'b0, 2'd0);
        push(32'h00000000, 1'b1, 2'd0);
        beat(8'h01, 1'b0, 1'b0);
        beat(8'h02, 1'b0, 1'b0);
        beat(8'h03, 1'b0, 1'b0);
        beat(8'h04, 1'b1, 1'b0);
        wait_done("four");

        // empty message
        do_reset();
        push(32'h00000000, 1'b1, 2'd0);
        beat(8'hEE, 1'b1, 1'b1);
        wait_done("empty");

        // 5 bytes with back-pressure on the first word
        do_reset();
        buffer_full = 1'b1;
        push(32'hA0A1A2A3, 1'b0, 2'd0);
        push(32'hA4000000, 1'b1, 2'd1);
        beat(8'hA0, 1'b0, 1'b0);
        beat(8'hA1, 1'b0, 1'b0);
        beat(8'hA2, 1'b0, 1'b0);
        beat(8'hA3, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_in_held", in, 32'hA0A1A2A3);
            chk("bp_s_ready", {31'd0, s_ready}, 32'd0);
        end
        @(posedge clk); #1;
        buffer_full = 1'b0;
        beat(8'hA4, 1'b1, 1'b0);
        wait_done("five");

        // reset mid-message discards partial word
        do_reset();
        beat(8'h11, 1'b0, 1'b0);
        beat(8'h22, 1'b0, 1'b0);
        do_reset();
        push(32'hFF000000, 1'b1, 2'd1);
        beat(8'hFF, 1'b1, 1'b0);
        wait_done("midrst");

        // beats after done are ignored
        s_data = 8'h55; s_last = 1'b1; s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_done_s_ready", {31'd0, s_ready}, 32'd0);
            chk("post_done_done", {31'd0, done}, 32'd1);
            chk("post_done_msg_bytes", msg_bytes, ecnt(1));
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("final_sb_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
